// File: rtl/wb_mon_pkg.sv
// Shared types for the Wishbone bus monitor.
// Status codes, FSM state encoding and log entry width.
package wb_mon_pkg;

  localparam logic [1:0] STAT_ACK = 2'd0;
  localparam logic [1:0] STAT_ERR = 2'd1;
  localparam logic [1:0] STAT_RTY = 2'd2;
  localparam logic [1:0] STAT_TMO = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_HUNG = 2'd2;

  // Log entry layout is {adr, dat, we, status}.
  function automatic int log_w(input int aw, input int dw);
    return aw + dw + 3;
  endfunction

endpackage

// File: rtl/wb_mon_fifo.sv
// First-word-fall-through FIFO for the monitor log.
// Push while full is accepted only when a pop frees a slot.
module wb_mon_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  // Storage array; contents only matter behind valid pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  // Read/write pointers with wrap bit for full/empty detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wb_bus_monitor.sv
// Passive Wishbone monitor: transfer log, counters, timeout.
// Define WB_MON_CHECK_EN to compile in the protocol checker.
module wb_bus_monitor
  import wb_mon_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 1024,
  parameter int LOG_DEPTH = 16
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [AW-1:0]   mon_adr_i,
  input  logic [DW-1:0]   mon_dat_m2s_i,
  input  logic [DW-1:0]   mon_dat_s2m_i,
  input  logic [DW/8-1:0] mon_sel_i,
  input  logic            mon_we_i,
  input  logic            mon_cyc_i,
  input  logic            mon_stb_i,
  input  logic            mon_ack_i,
  input  logic            mon_err_i,
  input  logic            mon_rty_i,
  input  logic            clear_i,
  input  logic            log_pop_i,
  output logic            log_valid_o,
  output logic [AW-1:0]   log_adr_o,
  output logic [DW-1:0]   log_dat_o,
  output logic            log_we_o,
  output logic [1:0]      log_status_o,
  output logic            log_overflow_o,
  output logic [31:0]     txn_count_o,
  output logic [15:0]     err_count_o,
  output logic            timeout_o,
  output logic            violation_o,
  output logic            irq_o
);

  localparam int LW = log_w(AW, DW);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   wait_cnt;
  logic          active;
  logic          term;
  logic          done_evt;
  logic          tmo_evt;
  logic [1:0]    stat;
  logic [DW-1:0] dat_sel;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [LW-1:0] push_data;
  logic [LW-1:0] head;
  logic          ovf_evt;
  logic          tmo_nxt;
  logic          ovf_nxt;
  logic          viol_nxt;

  assign active  = mon_cyc_i && mon_stb_i;
  assign term    = mon_ack_i || mon_err_i || mon_rty_i;
  assign dat_sel = mon_we_i ? mon_dat_m2s_i : mon_dat_s2m_i;

  // Termination priority err > rty > ack.
  always_comb begin
    stat = STAT_ACK;
    unique case (1'b1)
      mon_err_i: stat = STAT_ERR;
      mon_rty_i: stat = STAT_RTY;
      default:   stat = STAT_ACK;
    endcase
  end

  // Next-state and event decode for the transfer tracker.
  always_comb begin
    state_nxt = state;
    done_evt  = 1'b0;
    tmo_evt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (active && term) done_evt = 1'b1;
        else if (active)    state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!active) begin
          state_nxt = S_IDLE;
        end else if (term) begin
          done_evt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_cnt == TMO_LAST) begin
          tmo_evt   = 1'b1;
          state_nxt = S_HUNG;
        end
      end
      S_HUNG: begin
        if (!active) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign push = !clear_i && (done_evt || tmo_evt);
  assign pop  = log_pop_i && !empty;

  assign push_data = tmo_evt ?
    {mon_adr_i, mon_dat_m2s_i, mon_we_i, STAT_TMO} :
    {mon_adr_i, dat_sel, mon_we_i, stat};

  assign ovf_evt = push && full && !pop;
  assign tmo_nxt = timeout_o || tmo_evt;
  assign ovf_nxt = log_overflow_o || ovf_evt;

  // FSM state and wait-cycle counter.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else if (clear_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != S_WAIT)  wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
      else                      wait_cnt <= 16'd1;
    end
  end

  // Saturating transaction and error counters.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      txn_count_o <= '0;
      err_count_o <= '0;
    end else if (clear_i) begin
      txn_count_o <= '0;
      err_count_o <= '0;
    end else begin
      if ((done_evt || tmo_evt) && txn_count_o != '1)
        txn_count_o <= txn_count_o + 32'd1;
      if (((done_evt && stat == STAT_ERR) || tmo_evt) &&
          err_count_o != '1)
        err_count_o <= err_count_o + 16'd1;
    end
  end

  // Sticky flags; irq uses next values so it rises with them.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      timeout_o      <= 1'b0;
      log_overflow_o <= 1'b0;
      irq_o          <= 1'b0;
    end else if (clear_i) begin
      timeout_o      <= 1'b0;
      log_overflow_o <= 1'b0;
      irq_o          <= 1'b0;
    end else begin
      timeout_o      <= tmo_nxt;
      log_overflow_o <= ovf_nxt;
      irq_o          <= tmo_nxt || ovf_nxt || viol_nxt;
    end
  end

`ifdef WB_MON_CHECK_EN
  logic [AW-1:0]   adr_q;
  logic            we_q;
  logic [DW/8-1:0] sel_q;
  logic            multi;
  logic            chg;
  logic            viol_evt;

  assign multi = (mon_ack_i && mon_err_i) ||
                 (mon_ack_i && mon_rty_i) ||
                 (mon_err_i && mon_rty_i);
  assign chg   = (mon_adr_i != adr_q) ||
                 (mon_we_i != we_q) ||
                 (mon_sel_i != sel_q);
  assign viol_evt = multi || (term && !active) ||
                    (state == S_WAIT && active && chg);
  assign viol_nxt = violation_o || viol_evt;

  // Capture request attributes while idle for the WAIT check.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
    end else if (state == S_IDLE) begin
      adr_q <= mon_adr_i;
      we_q  <= mon_we_i;
      sel_q <= mon_sel_i;
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)       violation_o <= 1'b0;
    else if (clear_i) violation_o <= 1'b0;
    else              violation_o <= viol_nxt;
  end
`else
  logic sel_unused;

  assign sel_unused  = ^mon_sel_i;
  assign viol_nxt    = 1'b0;
  assign violation_o = 1'b0;
`endif

  wb_mon_fifo #(
    .W     (LW),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .clr   (clear_i),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign log_valid_o = !empty;
  assign {log_adr_o, log_dat_o, log_we_o, log_status_o} =
    log_valid_o ? head : '0;

endmodule

// File: tb/tb_wb_bus_monitor.sv
// Directed self-checking bench for wb_bus_monitor.
// Uses TIMEOUT=8 and LOG_DEPTH=4.
module tb_wb_bus_monitor;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] mon_adr_i;
  logic [31:0] mon_dat_m2s_i;
  logic [31:0] mon_dat_s2m_i;
  logic [3:0]  mon_sel_i;
  logic        mon_we_i, mon_cyc_i, mon_stb_i;
  logic        mon_ack_i, mon_err_i, mon_rty_i;
  logic        clear_i, log_pop_i;
  logic        log_valid_o;
  logic [31:0] log_adr_o;
  logic [31:0] log_dat_o;
  logic        log_we_o;
  logic [1:0]  log_status_o;
  logic        log_overflow_o;
  logic [31:0] txn_count_o;
  logic [15:0] err_count_o;
  logic        timeout_o, violation_o, irq_o;

  int checks = 0;
  int errors = 0;

`ifdef WB_MON_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 wb_clk = ~wb_clk;

  wb_bus_monitor #(
    .AW(32), .DW(32), .TIMEOUT(8), .LOG_DEPTH(4)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .mon_adr_i(mon_adr_i),
    .mon_dat_m2s_i(mon_dat_m2s_i),
    .mon_dat_s2m_i(mon_dat_s2m_i),
    .mon_sel_i(mon_sel_i), .mon_we_i(mon_we_i),
    .mon_cyc_i(mon_cyc_i), .mon_stb_i(mon_stb_i),
    .mon_ack_i(mon_ack_i), .mon_err_i(mon_err_i),
    .mon_rty_i(mon_rty_i),
    .clear_i(clear_i), .log_pop_i(log_pop_i),
    .log_valid_o(log_valid_o), .log_adr_o(log_adr_o),
    .log_dat_o(log_dat_o), .log_we_o(log_we_o),
    .log_status_o(log_status_o),
    .log_overflow_o(log_overflow_o),
    .txn_count_o(txn_count_o), .err_count_o(err_count_o),
    .timeout_o(timeout_o), .violation_o(violation_o),
    .irq_o(irq_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic bus_idle();
    mon_cyc_i = 0; mon_stb_i = 0; mon_we_i = 0;
    mon_ack_i = 0; mon_err_i = 0; mon_rty_i = 0;
  endtask

  task automatic start(input logic [31:0] a, input logic we,
                       input logic [31:0] m2s, input logic [31:0] s2m);
    mon_adr_i = a; mon_we_i = we; mon_sel_i = 4'hF;
    mon_dat_m2s_i = m2s; mon_dat_s2m_i = s2m;
    mon_cyc_i = 1; mon_stb_i = 1;
  endtask

  task automatic do_pop();
    log_pop_i = 1; tick(); log_pop_i = 0;
  endtask

  task automatic do_clear();
    clear_i = 1; tick(); clear_i = 0;
  endtask

  task automatic test_reset();
    wb_rst = 1; clear_i = 0; log_pop_i = 0;
    mon_adr_i = 0; mon_dat_m2s_i = 0; mon_dat_s2m_i = 0;
    mon_sel_i = 0; bus_idle();
    tick(2);
    if (log_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h want 0", log_valid_o); end checks++;
    if (txn_count_o !== 32'd0) begin errors++; $display("FAIL rst_txn: got %0h want 0", txn_count_o); end checks++;
    if (err_count_o !== 16'd0) begin errors++; $display("FAIL rst_err: got %0h want 0", err_count_o); end checks++;
    if ({timeout_o, violation_o, log_overflow_o, irq_o} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {timeout_o, violation_o, log_overflow_o, irq_o}); end checks++;
    if (log_adr_o !== 32'd0) begin errors++; $display("FAIL rst_adr: got %0h want 0", log_adr_o); end checks++;
    wb_rst = 0;
    tick();
  endtask

  task automatic test_single_write();
    start(32'h100, 1, 32'hDEADBEEF, 32'h0);
    tick(3);
    if (log_valid_o !== 1'b0) begin errors++; $display("FAIL wr_early: got %0h want 0", log_valid_o); end checks++;
    mon_ack_i = 1; tick(); bus_idle();
    if (log_valid_o !== 1'b1) begin errors++; $display("FAIL wr_valid: got %0h want 1", log_valid_o); end checks++;
    if (log_adr_o !== 32'h100) begin errors++; $display("FAIL wr_adr: got %0h want 100", log_adr_o); end checks++;
    if (log_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_dat: got %0h want deadbeef", log_dat_o); end checks++;
    if ({log_we_o, log_status_o} !== 3'b100) begin errors++; $display("FAIL wr_we_stat: got %b want 100", {log_we_o, log_status_o}); end checks++;
    if (txn_count_o !== 32'd1) begin errors++; $display("FAIL wr_txn: got %0d want 1", txn_count_o); end checks++;
    if (err_count_o !== 16'd0) begin errors++; $display("FAIL wr_errcnt: got %0d want 0", err_count_o); end checks++;
    do_pop();
    if (log_valid_o !== 1'b0) begin errors++; $display("FAIL wr_popped: got %0h want 0", log_valid_o); end checks++;
  endtask

  task automatic test_read_err();
    start(32'h20, 0, 32'hAAAA, 32'h55);
    mon_err_i = 1; tick(); bus_idle();
    if (log_status_o !== 2'd1) begin errors++; $display("FAIL rderr_stat: got %0d want 1", log_status_o); end checks++;
    if (log_dat_o !== 32'h55) begin errors++; $display("FAIL rderr_dat: got %0h want 55", log_dat_o); end checks++;
    if ({log_we_o, log_adr_o} !== {1'b0, 32'h20}) begin errors++; $display("FAIL rderr_adr_we: got %0h want 20", {log_we_o, log_adr_o}); end checks++;
    if (err_count_o !== 16'd1) begin errors++; $display("FAIL rderr_errcnt: got %0d want 1", err_count_o); end checks++;
    if (txn_count_o !== 32'd2) begin errors++; $display("FAIL rderr_txn: got %0d want 2", txn_count_o); end checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL rderr_irq: got %0h want 0", irq_o); end checks++;
    do_pop();
  endtask

  task automatic test_timeout();
    start(32'h300, 1, 32'h1234, 32'h0);
    tick(7);
    if ({log_valid_o, timeout_o} !== 2'b00) begin errors++; $display("FAIL tmo_early: got %b want 00", {log_valid_o, timeout_o}); end checks++;
    tick();
    if (log_valid_o !== 1'b1) begin errors++; $display("FAIL tmo_valid: got %0h want 1", log_valid_o); end checks++;
    if (log_status_o !== 2'd3) begin errors++; $display("FAIL tmo_stat: got %0d want 3", log_status_o); end checks++;
    if ({log_adr_o, log_dat_o} !== {32'h300, 32'h1234}) begin errors++; $display("FAIL tmo_entry: got %0h/%0h want 300/1234", log_adr_o, log_dat_o); end checks++;
    if ({timeout_o, irq_o} !== 2'b11) begin errors++; $display("FAIL tmo_flags: got %b want 11", {timeout_o, irq_o}); end checks++;
    if (err_count_o !== 16'd2) begin errors++; $display("FAIL tmo_errcnt: got %0d want 2", err_count_o); end checks++;
    if (txn_count_o !== 32'd3) begin errors++; $display("FAIL tmo_txn: got %0d want 3", txn_count_o); end checks++;
    tick(12);
    mon_ack_i = 1; tick(); bus_idle(); tick();
    if (txn_count_o !== 32'd3) begin errors++; $display("FAIL tmo_late_txn: got %0d want 3", txn_count_o); end checks++;
    do_pop();
    if (log_valid_o !== 1'b0) begin errors++; $display("FAIL tmo_late_log: got %0h want 0", log_valid_o); end checks++;
    do_clear();
    if ({timeout_o, irq_o, txn_count_o} !== 34'd0) begin errors++; $display("FAIL tmo_clear: got %0h want 0", {timeout_o, irq_o, txn_count_o}); end checks++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      start(32'(i), 1, 32'(i + 100), 32'h0);
      mon_ack_i = 1; tick();
    end
    bus_idle();
    if ({log_valid_o, log_overflow_o, irq_o} !== 3'b111) begin errors++; $display("FAIL ovf_flags: got %b want 111", {log_valid_o, log_overflow_o, irq_o}); end checks++;
    if (txn_count_o !== 32'd5) begin errors++; $display("FAIL ovf_txn: got %0d want 5", txn_count_o); end checks++;
    for (int i = 0; i < 4; i++) begin
      if (log_adr_o !== 32'(i)) begin errors++; $display("FAIL ovf_order%0d: got %0h want %0h", i, log_adr_o, i); end checks++;
      do_pop();
    end
    if (log_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0h want 0", log_valid_o); end checks++;
    do_clear();
    log_pop_i = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0 && log_adr_o !== 32'(16 + i - 1)) begin errors++; $display("FAIL pop_order%0d: got %0h want %0h", i, log_adr_o, 16 + i - 1); end
      if (i > 0) checks++;
      start(32'(16 + i), 1, 32'h0, 32'h0);
      mon_ack_i = 1; tick();
    end
    bus_idle();
    if (log_adr_o !== 32'h14) begin errors++; $display("FAIL pop_last: got %0h want 14", log_adr_o); end checks++;
    tick(); log_pop_i = 0;
    if ({log_valid_o, log_overflow_o} !== 2'b00) begin errors++; $display("FAIL pop_noovf: got %b want 00", {log_valid_o, log_overflow_o}); end checks++;
    if (txn_count_o !== 32'd5) begin errors++; $display("FAIL pop_txn: got %0d want 5", txn_count_o); end checks++;
    do_clear();
  endtask

  task automatic test_checker();
    start(32'h40, 0, 32'h0, 32'h77);
    mon_ack_i = 1; mon_err_i = 1; tick(); bus_idle();
    if (log_status_o !== 2'd1) begin errors++; $display("FAIL chk_stat: got %0d want 1", log_status_o); end checks++;
    if (log_dat_o !== 32'h77) begin errors++; $display("FAIL chk_dat: got %0h want 77", log_dat_o); end checks++;
    if (violation_o !== CHK) begin errors++; $display("FAIL chk_viol: got %0h want %0h", violation_o, CHK); end checks++;
    if (irq_o !== CHK) begin errors++; $display("FAIL chk_irq: got %0h want %0h", irq_o, CHK); end checks++;
    do_clear();
    if ({violation_o, log_valid_o} !== 2'b00) begin errors++; $display("FAIL chk_clear: got %b want 00", {violation_o, log_valid_o}); end checks++;
  endtask

  task automatic test_clear_mid_wait();
    start(32'h80, 1, 32'h1, 32'h0);
    mon_ack_i = 1; tick(); bus_idle();
    if (txn_count_o !== 32'd1) begin errors++; $display("FAIL clr_pre_txn: got %0d want 1", txn_count_o); end checks++;
    start(32'h600, 1, 32'h2, 32'h0);
    tick(3);
    clear_i = 1; mon_ack_i = 1; tick(); clear_i = 0; bus_idle();
    if ({txn_count_o, err_count_o} !== 48'd0) begin errors++; $display("FAIL clr_cnt: got %0h want 0", {txn_count_o, err_count_o}); end checks++;
    if ({log_valid_o, timeout_o, violation_o, log_overflow_o, irq_o} !== 5'b0) begin errors++; $display("FAIL clr_flags: got %b want 00000", {log_valid_o, timeout_o, violation_o, log_overflow_o, irq_o}); end checks++;
    start(32'h500, 0, 32'h0, 32'h99);
    mon_ack_i = 1; tick(); bus_idle();
    if ({log_valid_o, log_adr_o, log_dat_o} !== {1'b1, 32'h500, 32'h99}) begin errors++; $display("FAIL clr_next: got %0h/%0h want 500/99", log_adr_o, log_dat_o); end checks++;
    if (txn_count_o !== 32'd1) begin errors++; $display("FAIL clr_next_txn: got %0d want 1", txn_count_o); end checks++;
    do_pop();
  endtask

  task automatic test_reset_mid_wait();
    start(32'h700, 1, 32'h3, 32'h0);
    tick(3);
    #2 wb_rst = 1;
    #1;
    if ({txn_count_o, log_valid_o} !== 33'd0) begin errors++; $display("FAIL rst_mid: got %0h want 0", {txn_count_o, log_valid_o}); end checks++;
    if ({timeout_o, violation_o, log_overflow_o, irq_o} !== 4'b0) begin errors++; $display("FAIL rst_mid_flags: got %b want 0000", {timeout_o, violation_o, log_overflow_o, irq_o}); end checks++;
    tick(); bus_idle(); wb_rst = 0;
    tick();
    start(32'h710, 1, 32'hCAFE, 32'h0);
    mon_ack_i = 1; tick(); bus_idle();
    if ({log_valid_o, log_adr_o, log_dat_o} !== {1'b1, 32'h710, 32'hCAFE}) begin errors++; $display("FAIL rst_next: got %0h/%0h want 710/cafe", log_adr_o, log_dat_o); end checks++;
    if (txn_count_o !== 32'd1) begin errors++; $display("FAIL rst_next_txn: got %0d want 1", txn_count_o); end checks++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_err();
    test_timeout();
    test_overflow();
    test_checker();
    test_clear_mid_wait();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
